// File: rtl/bus_master_pkg.sv
// bus_master_pkg: shared bus width and state encodings for the bus master and its responders
package bus_master_pkg;
  localparam int BITW = 8;
  typedef enum logic [2:0] {M_IDLE, M_ADDR, M_WDATA, M_RDATA, M_RCAP} mst_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rsp_state_e;
endpackage

// File: rtl/tri_buf.sv
// tri_buf: drives din onto the shared bus while rw is high, otherwise releases it
module tri_buf
  import bus_master_pkg::*;
(
  input  logic [BITW-1:0] din,
  input  logic            rw,
  inout  wire  [BITW-1:0] bus
);
  assign bus = rw ? din : {BITW{1'bz}};
endmodule

// File: rtl/bus_master.sv
// bus_master: single-outstanding host request to shared tri-state memory bus; BUS_MASTER_READBACK_EN adds write read-back checking
module bus_master
  import bus_master_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [BITW-1:0] req_addr,
  input  logic [BITW-1:0] req_wdata,
  output logic            resp_valid,
  output logic [BITW-1:0] resp_rdata,
  output logic            resp_err,
  output logic            bus_enable,
  output logic            bus_rw,
  inout  wire  [BITW-1:0] bus
);
  mst_state_e      state_q, state_d;
  logic [BITW-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic            write_q, write_d;
  logic            en_q, en_d, rw_q, rw_d, drv_q, drv_d;
  logic [BITW-1:0] dout_q, dout_d;
  logic            rv_q, rv_d, err_q, err_d;
  logic [BITW-1:0] rdata_q, rdata_d;
  logic [BITW-1:0] cap_q, cap_d;
  logic            wr_pass;
`ifdef BUS_MASTER_READBACK_EN
  logic            rb_q, rb_d;
  assign wr_pass = write_q & ~rb_q;
`else
  assign wr_pass = write_q;
`endif

  assign req_ready  = (state_q == M_IDLE) & ~reset;
  assign resp_valid = rv_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign bus_enable = en_q;
  assign bus_rw     = rw_q;

  tri_buf u_buf (
    .din (dout_q),
    .rw  (drv_q),
    .bus (bus)
  );

  // next state plus bus drives for the state being entered, so every output is a flop
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    en_d    = 1'b0;
    rw_d    = 1'b0;
    drv_d   = 1'b0;
    dout_d  = dout_q;
    rv_d    = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
`ifdef BUS_MASTER_READBACK_EN
    rb_d    = rb_q;
`endif
    case (state_q)
      M_IDLE: if (req_valid) begin
        state_d = M_ADDR;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        write_d = req_write;
        en_d    = 1'b1;
        rw_d    = req_write;
        drv_d   = 1'b1;
        dout_d  = req_addr;
`ifdef BUS_MASTER_READBACK_EN
        rb_d    = 1'b0;
`endif
      end
      M_ADDR: begin
        state_d = wr_pass ? M_WDATA : M_RDATA;
        en_d    = 1'b1;
        rw_d    = wr_pass;
        drv_d   = wr_pass;
        dout_d  = wr_pass ? wdata_q : dout_q;
      end
      M_WDATA: begin
`ifdef BUS_MASTER_READBACK_EN
        state_d = M_ADDR;
        rb_d    = 1'b1;
        en_d    = 1'b1;
        drv_d   = 1'b1;
        dout_d  = addr_q;
`else
        state_d = M_IDLE;
        rv_d    = 1'b1;
`endif
      end
      M_RDATA: state_d = M_RCAP;
      M_RCAP: begin
        state_d = M_IDLE;
        rv_d    = 1'b1;
        rdata_d = cap_q;
`ifdef BUS_MASTER_READBACK_EN
        err_d   = rb_q & (cap_q != wdata_q);
`endif
      end
      default: state_d = M_IDLE;
    endcase
  end

  // read data is sampled mid-cycle while the responder drives the high half of RCAP
  always_comb cap_d = (state_q == M_RCAP) ? bus : cap_q;

  // falling-edge capture register
  always_ff @(negedge clock) cap_q <= cap_d;

  // state and registered outputs; reset aborts any transfer without a response
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= M_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      en_q    <= 1'b0;
      rw_q    <= 1'b0;
      drv_q   <= 1'b0;
      dout_q  <= '0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
`ifdef BUS_MASTER_READBACK_EN
      rb_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      en_q    <= en_d;
      rw_q    <= rw_d;
      drv_q   <= drv_d;
      dout_q  <= dout_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
`ifdef BUS_MASTER_READBACK_EN
      rb_q    <= rb_d;
`endif
    end
  end
endmodule

// File: tb/tb_bus_master.sv
// tb_bus_master: directed bench with a ram responder and a latency-table reference model
module tb_bus_master;
  import bus_master_pkg::*;
`ifdef BUS_MASTER_READBACK_EN
  localparam int WLAT = 5;
`else
  localparam int WLAT = 2;
`endif
  logic       clock = 0, reset = 1, req_valid = 0, req_write = 0;
  logic [7:0] req_addr = 0, req_wdata = 0;
  logic       req_ready, resp_valid, resp_err, bus_enable, bus_rw;
  logic [7:0] resp_rdata;
  wire  [7:0] bus;
  logic       ram_drv = 0;
  logic [7:0] ram_out = 0;
  int         vectors = 0, miscompares = 0, cyc = 0;

  assign bus = ram_drv ? ram_out : 8'bz;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  bus_master dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .bus_enable(bus_enable), .bus_rw(bus_rw), .bus(bus)
  );

  task automatic chk8(input string n, input logic [7:0] a, input logic [7:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %h want %h", n, cyc, a, e);
    end
  endtask

  // ram responder: address on first enabled cycle, data on second; drives read data in the high half after
  logic [7:0] ram_mem [256];
  logic       se, srw, rrw;
  logic [7:0] sbus, ra;
  int         ph = 0;
  bit         corrupt = 0;
  always @(negedge clock) begin se = bus_enable; srw = bus_rw; sbus = bus; end
  always @(posedge clock) begin
    if (reset) ph = 0;
    else if (se === 1'b1) begin
      if (ph == 0) begin ra = sbus; rrw = srw; ph = 1; end
      else begin
        ph = 0;
        if (rrw) ram_mem[ra] = sbus;
        else begin
          #1 ram_out = corrupt ? 8'h00 : ram_mem[ra]; ram_drv = 1;
          @(negedge clock); #1 ram_drv = 0;
        end
      end
    end
  end

  // reference model: per-cycle expectations derived from request latency rules
  bit         chk = 0;
  int         busy_until = 0;
  logic [7:0] mm [256];
  bit         e_en [int];
  bit         e_rw [int];
  bit         e_rv [int];
  bit         e_err [int];
  logic [7:0] e_rd [int];
  logic [7:0] hold_rd = 0;

  task automatic model_accept(input int t);
    if (req_write) begin
      mm[req_addr] = req_wdata;
      e_en[t] = 1; e_en[t+1] = 1; e_rw[t] = 1; e_rw[t+1] = 1;
`ifdef BUS_MASTER_READBACK_EN
      e_en[t+2] = 1; e_en[t+3] = 1;
      e_rv[t+5] = 1;
      e_rd[t+5] = corrupt ? 8'h00 : req_wdata;
      e_err[t+5] = corrupt && req_wdata != 8'h00;
      busy_until = t + 5;
`else
      e_rv[t+2] = 1; e_err[t+2] = 0;
      busy_until = t + 2;
`endif
    end else begin
      e_en[t] = 1; e_en[t+1] = 1;
      e_rv[t+3] = 1; e_err[t+3] = 0;
      e_rd[t+3] = corrupt ? 8'h00 : mm[req_addr];
      busy_until = t + 3;
    end
  endtask

  always @(negedge clock) begin
    if (chk) begin
      if (e_rd.exists(cyc)) hold_rd = e_rd[cyc];
      chk8("req_ready", req_ready, !reset && cyc >= busy_until);
      chk8("bus_enable", bus_enable, e_en.exists(cyc));
      chk8("bus_rw", bus_rw, e_rw.exists(cyc));
      chk8("resp_valid", resp_valid, e_rv.exists(cyc));
      if (e_rv.exists(cyc)) chk8("resp_err", resp_err, e_err[cyc]);
      chk8("resp_rdata", resp_rdata, hold_rd);
      if (reset) begin
        for (int k = cyc + 1; k <= cyc + 8; k++) begin
          e_en.delete(k); e_rw.delete(k); e_rv.delete(k); e_err.delete(k); e_rd.delete(k);
        end
        e_rd[cyc+1] = 8'h00;
        busy_until = cyc + 1;
      end else if (req_valid && cyc >= busy_until) model_accept(cyc + 1);
    end
  end

  logic [7:0] scr_l [3];

  task automatic do_req(input logic w, input logic [7:0] a, input logic [7:0] d, input bit scr, output int acc);
    int k = 0;
    acc = -1;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (req_ready) begin acc = cyc + 1; break; end
      @(posedge clock); #1;
      if (scr) begin k++; req_addr = scr_l[k % 3]; end
    end
    @(posedge clock); #1 req_valid = 0;
    if (acc < 0) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout @cyc %0d: got no accept want accept within 20 cycles", cyc);
    end
  endtask

  task automatic wait_resp(output int rc, output logic e, output logic [7:0] rd);
    rc = -1; e = 0; rd = 0;
    for (int i = 0; i < 20 && rc < 0; i++) begin
      @(negedge clock);
      if (resp_valid) begin rc = cyc; e = resp_err; rd = resp_rdata; end
    end
    if (rc < 0) begin
      vectors++; miscompares++;
      $display("FAIL resp_timeout @cyc %0d: got no resp_valid want resp_valid within 20 cycles", cyc);
    end
    @(posedge clock); #1;
  endtask

  initial begin
    int a1, a2, rc, seen;
    logic e;
    logic [7:0] rd;
    scr_l[0] = 8'h10; scr_l[1] = 8'h00; scr_l[2] = 8'h33;
    for (int i = 0; i < 256; i++) begin ram_mem[i] = 0; mm[i] = 0; end
    @(posedge clock); #1 chk = 1;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    chk8("ready_after_reset", req_ready, 1'b1);
    chk8("rdata_reset", resp_rdata, 8'h00);
    @(posedge clock); #1;
    // write 0x3C to 0x10
    do_req(1, 8'h10, 8'h3C, 0, a1);
    wait_resp(rc, e, rd);
    chk8("wr_latency", 8'(rc - a1), 8'(WLAT));
    chk8("wr_err", e, 1'b0);
    chk8("ram_10", ram_mem[8'h10], 8'h3C);
    // read it back
    do_req(0, 8'h10, 8'h00, 0, a1);
    wait_resp(rc, e, rd);
    chk8("rd_latency", 8'(rc - a1), 8'd3);
    chk8("rd_data_3c", rd, 8'h3C);
    // back-to-back write then read
    do_req(1, 8'h00, 8'hFF, 0, a1);
    do_req(0, 8'h00, 8'h00, 0, a2);
    chk8("b2b_accept", 8'(a2 - a1), 8'(WLAT + 1));
    wait_resp(rc, e, rd);
    chk8("b2b_rd_latency", 8'(rc - a2), 8'd3);
    chk8("b2b_rd_data", rd, 8'hFF);
    // reset during RDATA
    do_req(0, 8'h10, 8'h00, 0, a1);
    @(posedge clock); #1 reset = 1;
    @(posedge clock); #1 reset = 0;
    @(negedge clock);
    chk8("abort_rv", resp_valid, 1'b0);
    chk8("abort_en", bus_enable, 1'b0);
    chk8("abort_rdata", resp_rdata, 8'h00);
    chk8("abort_ready", req_ready, 1'b1);
    seen = 0;
    repeat (4) begin @(negedge clock); seen |= int'(resp_valid); end
    chk8("abort_no_resp", 8'(seen), 8'h00);
    @(posedge clock); #1;
    // request held valid while busy with a changing address
    do_req(1, 8'h33, 8'h5A, 0, a1);
    do_req(0, 8'h10, 8'h00, 1, a2);
    wait_resp(rc, e, rd);
    chk8("held_req_data", rd, 8'h5A);
`ifdef BUS_MASTER_READBACK_EN
    do_req(1, 8'h20, 8'hA5, 0, a1);
    wait_resp(rc, e, rd);
    chk8("rb_latency", 8'(rc - a1), 8'd5);
    chk8("rb_err_ok", e, 1'b0);
    chk8("rb_rdata_ok", rd, 8'hA5);
    corrupt = 1;
    do_req(1, 8'h21, 8'hA5, 0, a1);
    wait_resp(rc, e, rd);
    chk8("rb_err_bad", e, 1'b1);
    chk8("rb_rdata_bad", rd, 8'h00);
    corrupt = 0;
`endif
    repeat (3) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog @cyc %0d: got no finish want finish", cyc);
    $fatal(1);
  end
endmodule
